// File: rtl/dfp_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the DFP arbiter.
// slave:  the arbiter's view (requests in, memory strobes out).
// master: the environment's view (caches and memory model).
interface dfp_arbiter_if;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;

  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;

  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, dfp_rdata, dfp_resp,
    output i_rdata, i_resp, d_rdata, d_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
  );

  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata, dfp_rdata, dfp_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
  );
endinterface

// File: rtl/dfp_arbiter.sv
// Two-requester arbiter sharing one memory port between I-cache and D-cache.
// One access outstanding at most; the memory strobes come straight from
// registers captured when a grant is made.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise the D-cache always wins a tie.
//
// state   | meaning
// IDLE    | no access outstanding, arbitrate incoming requests
// GRANT_I | I-cache line read outstanding on the memory port
// GRANT_D | D-cache read or writeback outstanding on the memory port
module dfp_arbiter (
  input  logic         clk,
  input  logic         rst,
  dfp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t       state_q, state_d;
  logic [31:0]  addr_q;
  logic [255:0] wdata_q;
  logic         read_q;
  logic         write_q;

  logic         d_req;
  logic         tie_to_d;
  logic         take_i;
  logic         take_d;
  logic         i_resp;
  logic         d_resp;

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Remember who completed last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (i_resp || d_resp) begin
      last_d_q <= d_resp;
    end
  end

  assign tie_to_d = ~last_d_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // Arbitration, completion detection and next state.
  always_comb begin
    state_d = state_q;
    take_i  = 1'b0;
    take_d  = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.i_read && d_req) begin
            take_d = tie_to_d;
            take_i = ~tie_to_d;
          end else begin
            take_i = bus.i_read;
            take_d = d_req;
          end
          if (take_d) begin
            state_d = GRANT_D;
          end else if (take_i) begin
            state_d = GRANT_I;
          end
        end
        GRANT_I: begin
          if (bus.dfp_resp) begin
            i_resp  = 1'b1;
            state_d = IDLE;
          end
        end
        GRANT_D: begin
          if (bus.dfp_resp) begin
            d_resp  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register plus capture of the winning request; strobes drop on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_d) begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        write_q <= bus.d_write;
        read_q  <= ~bus.d_write;
      end else if (take_i) begin
        addr_q  <= bus.i_addr;
        wdata_q <= '0;
        write_q <= 1'b0;
        read_q  <= 1'b1;
      end else if (i_resp || d_resp) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
    end
  end

  assign bus.dfp_addr  = addr_q;
  assign bus.dfp_wdata = wdata_q;
  assign bus.dfp_read  = read_q;
  assign bus.dfp_write = write_q;
  assign bus.i_resp    = i_resp;
  assign bus.d_resp    = d_resp;
  assign bus.i_rdata   = bus.dfp_rdata;
  assign bus.d_rdata   = bus.dfp_rdata;

endmodule

// File: tb/tb_dfp_arbiter.sv
// Self-checking bench for dfp_arbiter: expected grants are queued when
// requests are driven and popped as the arbiter drives the memory port.
module tb_dfp_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dfp_arbiter_if bus();

  dfp_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [31:0] addr, input logic [255:0] wdata);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Entered at a negedge with the arbiter idle and a request driven.
  task automatic serve(input int lat, input logic [255:0] line, input bit keep, input bit perturb);
    exp_t e;
    tick();
    bus.dfp_resp = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    chk("grant_d", bus.dfp_write | (bus.dfp_read & (bus.dfp_addr == e.addr) & e.is_d), e.is_d | e.wr);
    chk("dfp_read", bus.dfp_read, !e.wr);
    chk("dfp_write", bus.dfp_write, e.wr);
    chk("dfp_addr", bus.dfp_addr, e.addr);
    if (e.wr) chk("dfp_wdata", bus.dfp_wdata, e.wdata);
    for (int k = 1; k < lat; k++) begin
      if (perturb && k == 1) begin
        bus.i_addr  = $urandom() & 32'hFFFF_FFE0;
        bus.d_addr  = $urandom() & 32'hFFFF_FFE0;
        bus.d_wdata = {8{$urandom()}};
      end
      tick();
      chk("strobe_held", bus.dfp_read ^ bus.dfp_write, 1'b1);
      chk("no_resp_wait", {bus.i_resp, bus.d_resp}, 2'b00);
      chk("addr_held", bus.dfp_addr, e.addr);
      if (e.wr) chk("wdata_held", bus.dfp_wdata, e.wdata);
    end
    bus.dfp_resp  = 1'b1;
    bus.dfp_rdata = line;
    #1;
    chk("i_resp", bus.i_resp, !e.is_d);
    chk("d_resp", bus.d_resp, e.is_d);
    chk("rdata", e.is_d ? bus.d_rdata : bus.i_rdata, line);
    chk("strobe_at_resp", {bus.dfp_read, bus.dfp_write}, {!e.wr, e.wr});
    tick();
    bus.dfp_resp = 1'b0;
    if (!keep) begin
      if (e.is_d) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end else begin
        bus.i_read = 1'b0;
      end
    end
    #1;
    chk("resp_after", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("idle_strobes", {bus.dfp_read, bus.dfp_write}, 2'b00);
  endtask

  logic [255:0] line;
  bit           tie_d [4];

  initial begin
    bus.i_addr    = '0;
    bus.i_read    = 1'b0;
    bus.d_addr    = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_wdata   = '0;
    bus.dfp_rdata = '0;
    bus.dfp_resp  = 1'b0;
    tick();
    tick();
    chk("rst_strobes", {bus.dfp_read, bus.dfp_write}, 2'b00);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst_addr", bus.dfp_addr, 32'h0);
    chk("rst_wdata", bus.dfp_wdata, 256'h0);
    rst = 1'b0;

    // I-cache read, memory answers 3 cycles in.
    bus.i_addr = 32'h0000_1000;
    bus.i_read = 1'b1;
    push(1'b0, 1'b0, 32'h0000_1000, '0);
    line = {8{32'h1234_5678}};
    serve(3, line, 1'b0, 1'b0);

    // D-cache writeback, inputs scrambled while granted.
    bus.d_addr  = 32'h0000_2040;
    bus.d_wdata = {32{8'hA5}};
    bus.d_write = 1'b1;
    push(1'b1, 1'b1, 32'h0000_2040, {32{8'hA5}});
    serve(3, {8{32'hDEAD_BEEF}}, 1'b0, 1'b1);

    // Read and write together count as a write.
    bus.d_addr  = 32'h0000_3080;
    bus.d_wdata = {8{32'h0F0F_1E1E}};
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    push(1'b1, 1'b1, 32'h0000_3080, {8{32'h0F0F_1E1E}});
    serve(2, '0, 1'b0, 1'b0);

    // Stray memory response while idle.
    bus.dfp_resp = 1'b1;
    #1;
    chk("idle_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    tick();
    bus.dfp_resp = 1'b0;
    chk("idle_resp_state", {bus.dfp_read, bus.dfp_write}, 2'b00);

    // Reset two cycles into a D read; late memory response must be dropped.
    bus.d_addr = 32'h0000_40C0;
    bus.d_read = 1'b1;
    tick();
    chk("rr_pre_strobe", bus.dfp_read, 1'b1);
    tick();
    tick();
    rst        = 1'b1;
    bus.d_read = 1'b0;
    tick();
    chk("mid_rst_strobes", {bus.dfp_read, bus.dfp_write}, 2'b00);
    chk("mid_rst_addr", bus.dfp_addr, 32'h0);
    chk("mid_rst_wdata", bus.dfp_wdata, 256'h0);
    chk("mid_rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);

    // Release reset with a late response and a tie arriving together.
    rst          = 1'b0;
    bus.dfp_resp = 1'b1;
    bus.i_addr   = 32'h0000_5000;
    bus.d_addr   = 32'h0000_6020;
    bus.i_read   = 1'b1;
    bus.d_read   = 1'b1;
    #1;
    chk("late_resp", {bus.i_resp, bus.d_resp}, 2'b00);
`ifdef ARB_ROUND_ROBIN_EN
    tie_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    tie_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int n = 0; n < 4; n++) begin
      push(tie_d[n], 1'b0, tie_d[n] ? 32'h0000_6020 : 32'h0000_5000, '0);
    end
    for (int n = 0; n < 4; n++) begin
      serve(1 + n, {8{$urandom()}}, 1'b1, 1'b0);
    end
    bus.d_read = 1'b0;
    push(1'b0, 1'b0, 32'h0000_5000, '0);
    serve(2, {8{32'hCAFE_F00D}}, 1'b0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
